// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: FSM states, COMMAND field positions and HLT match.
package fetch_pkg;

  localparam int unsigned CMD_W    = 16;
  localparam int unsigned CLASS_HI = 15;
  localparam int unsigned CLASS_LO = 14;
  localparam int unsigned OP3_HI   = 7;
  localparam int unsigned OP3_LO   = 4;

  localparam logic [1:0] HLT_CLASS = 2'b11;
  localparam logic [3:0] HLT_OP3   = 4'b1111;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DROP,
    VALID,
    HALT
  } fetch_state_e;

  function automatic logic is_hlt(input logic [CMD_W-1:0] cmd);
    return (cmd[CLASS_HI:CLASS_LO] == HLT_CLASS) && (cmd[OP3_HI:OP3_LO] == HLT_OP3);
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory over req/ack and
// hands the fetched word to the decoder over valid/ready; stops for good on HLT.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned          ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [CMD_W-1:0]  imem_rdata,
  output logic [CMD_W-1:0]  COMMAND,
  output logic [ADDR_W-1:0] cmd_pc,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted
);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pend_q;
  logic [CMD_W-1:0]  cmd_q;
  logic [ADDR_W-1:0] cmd_pc_q;

  // A redirect during an outstanding request cannot cancel it; DROP waits for the
  // ack, throws the word away and restarts at the latest target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      pend_q   <= '0;
      cmd_q    <= '0;
      cmd_pc_q <= '0;
    end else begin
      case (state_q)
        IDLE: state_q <= FETCH;
        FETCH: begin
          if (imem_ack && redirect) begin
            pc_q <= redirect_pc;
          end else if (imem_ack) begin
            cmd_q    <= imem_rdata;
            cmd_pc_q <= pc_q;
            pc_q     <= pc_q + ADDR_W'(1);
            state_q  <= VALID;
          end else if (redirect) begin
            pend_q  <= redirect_pc;
            state_q <= DROP;
          end
        end
        DROP: begin
          if (imem_ack) begin
            pc_q    <= redirect ? redirect_pc : pend_q;
            state_q <= FETCH;
          end else if (redirect) begin
            pend_q <= redirect_pc;
          end
        end
        VALID: begin
          if (redirect) begin
            pc_q    <= redirect_pc;
            state_q <= FETCH;
          end else if (cmd_ready) begin
            state_q <= is_hlt(cmd_q) ? HALT : FETCH;
          end
        end
        HALT:    state_q <= HALT;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem_req  = (state_q == FETCH) || (state_q == DROP);
  assign imem_addr = pc_q;
  assign cmd_valid = (state_q == VALID);
  assign halted    = (state_q == HALT);
  assign COMMAND   = cmd_q;
  assign cmd_pc    = cmd_pc_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the instruction decoder.
- Owns the program counter and issues word reads to instruction memory over a req/ack handshake.
- Holds the returned 16-bit instruction as COMMAND for the decoder and hands it over with a valid/ready handshake.
- Applies branch redirects and stops permanently on HLT until reset.

Parameters:
- ADDR_W, 16, PC and instruction-memory word-address width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  read request; held high with imem_addr stable until imem_ack.
- imem_addr  out  ADDR_W  word address being fetched.
- imem_ack  in  1  one-cycle pulse; imem_rdata valid in the same cycle.
- imem_rdata  in  16  instruction word.
- COMMAND  out  16  held instruction, feeds the decoder.
- cmd_pc  out  ADDR_W  address COMMAND was fetched from.
- cmd_valid  out  1  COMMAND is valid.
- cmd_ready  in  1  downstream accepts COMMAND this cycle.
- redirect  in  1  branch taken (decoder PC_load qualified by the condition); one-cycle pulse.
- redirect_pc  in  ADDR_W  branch target.
- halted  out  1  HLT was consumed; fetch is stopped.

Behaviour:
- Reset is asynchronous and active-high. Reset values:
  - pc = RESET_PC, state = IDLE.
  - COMMAND = 0, cmd_pc = 0, cmd_valid = 0.
  - imem_req = 0, halted = 0.
- Outputs decode from state and registers:
  - imem_req = 1 in FETCH and DROP.
  - imem_addr = pc.
  - cmd_valid = 1 only in VALID.
  - halted = 1 only in HALT.
- HLT: COMMAND[15:14] == 2'b11 and COMMAND[7:4] == 4'b1111.
- State machine:
  - IDLE: always goes to FETCH on the next edge. redirect is ignored.
  - FETCH, on ack without redirect: COMMAND <= imem_rdata; cmd_pc <= pc; pc <= pc + 1 (wraps modulo 2^ADDR_W); go to VALID.
  - FETCH, on redirect without ack: pc is frozen; latch redirect_pc into pending target; go to DROP.
  - FETCH, on redirect and ack in the same cycle: discard rdata; pc <= redirect_pc; stay in FETCH.
  - DROP: keep imem_req high at the old address until ack, then discard rdata; pc <= pending target; go to FETCH.
  - DROP, on another redirect before ack: overwrite pending target (last one wins).
  - DROP, on redirect in the same cycle as ack: redirect_pc wins.
  - VALID, on redirect (priority over cmd_ready): cmd_valid drops; pc <= redirect_pc; go to FETCH. The held instruction is not considered accepted.
  - VALID, on cmd_ready without redirect and COMMAND is HLT: go to HALT.
  - VALID, on cmd_ready without redirect and COMMAND is not HLT: go to FETCH.
  - VALID, without cmd_ready: COMMAND and cmd_pc stay stable.
  - HALT: terminal. redirect and imem_ack are ignored; only rst leaves.
- Latency and throughput:
  - Request cycle with same-cycle ack: cmd_valid is high on the next cycle.
  - Peak throughput is one instruction per 2 cycles.
- Boundaries and error cases:
  - imem_ack outside FETCH/DROP is ignored.
  - Reset mid-fetch drops imem_req asynchronously; a late ack after reset release is ignored while in IDLE.
  - PC at 0xFFFF increments to 0x0000 with no flag.

Decomposition:
- Shared package fetch_pkg:
  - State enum: IDLE, FETCH, DROP, VALID, HALT.
  - HLT match constants: opcode class 2'b11, op3 4'b1111.
  - Field position constants for COMMAND, shared with the decoder.
- No sub-module; the PC register, state register and instruction register stay in one module.

Test Plan:
- Reset, then memory acks in the same cycle as each request with words 0xC006, 0x8123 at 0, 1 (cmd_ready = 1): imem_addr sequence 0, 1, 2; COMMAND 0xC006 with cmd_pc 0, then 0x8123 with cmd_pc 1, each valid one cycle.
- cmd_ready held low for 5 cycles with COMMAND = 0x8123 valid: COMMAND, cmd_pc and pc unchanged; imem_req = 0; cmd_valid stays 1.
- redirect to 0x0040 pulsed while in VALID with cmd_ready = 1: instruction is not taken; the next imem_addr is 0x0040.
- redirect to 0x0080 during FETCH with ack 3 cycles later: imem_addr stays at the old address until ack; data is discarded; the next request is to 0x0080; no cmd_valid in between.
- Fetch of 0xC0F0 (HLT) accepted: halted = 1 on the next cycle; imem_req stays 0; redirect and ack are ignored until rst.
- PC at 0xFFFF fetched and accepted: the next imem_addr is 0x0000. rst asserted mid-DROP: all outputs take reset values immediately.
